// File: rtl/ddr2_scrub_scheduler.sv
// Patrol-scrub sequencer: walks every address of every online rank, one read per interval,
// yielding to host traffic and writing back data that came back with a corrected error.
module ddr2_scrub_scheduler #(
  parameter int ADDR_WIDTH   = 25,
  parameter int NUM_RANKS    = 1,
  parameter int BURST_STRIDE = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scrub_enable,
  input  logic [31:0]           scrub_interval,
  input  logic [ADDR_WIDTH-1:0] scrub_last_addr,
  input  logic [NUM_RANKS-1:0]  rank_offline,
  input  logic                  host_busy,
  output logic                  scrub_req,
  output logic                  scrub_we,
  output logic [ADDR_WIDTH-1:0] scrub_addr,
  output logic [3:0]            scrub_rank,
  input  logic                  scrub_gnt,
  input  logic                  rd_valid,
  input  logic                  rd_ce,
  output logic                  scrub_active,
  output logic [31:0]           scrub_progress,
  output logic                  pass_done,
  output logic [15:0]           pass_count
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_REQ, S_RESP, S_WB, S_ADV} state_t;

  state_t                state_q, state_d;
  logic [31:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            rank_q, rank_d;
  logic                  skip_q, skip_d;
  logic                  pass_done_q, pass_done_d;
  logic [15:0]           pass_count_q, pass_count_d;
  logic                  active_q;

  logic [15:0]           online_w;
  logic                  any_online;
  logic [31:0]           interval_load;
  logic [ADDR_WIDTH:0]   sum_w;
  logic                  exhausted;
  logic                  nxt_found;
  logic                  nxt_wrap;
  logic [3:0]            nxt_rank;

  // Ranks beyond NUM_RANKS read as permanently offline.
  for (genvar gi = 0; gi < 16; gi++) begin : g_online
    if (gi < NUM_RANKS) begin : g_real
      assign online_w[gi] = ~rank_offline[gi];
    end else begin : g_absent
      assign online_w[gi] = 1'b0;
    end
  end

  assign any_online    = |online_w;
  assign interval_load = (scrub_interval == 32'd0) ? 32'd1 : scrub_interval;
  assign sum_w         = {1'b0, addr_q} + (ADDR_WIDTH+1)'(BURST_STRIDE);
  assign exhausted     = skip_q || (sum_w > {1'b0, scrub_last_addr});

  // Next online rank above the current one; failing that, wrap and search from rank 0.
  always_comb begin
    nxt_found = 1'b0;
    nxt_wrap  = 1'b0;
    nxt_rank  = 4'd0;
    for (int r = 0; r < 16; r++) begin
      if (!nxt_found && r > int'(rank_q) && online_w[r]) begin
        nxt_found = 1'b1;
        nxt_rank  = 4'(r);
      end
    end
    for (int r = 0; r < 16; r++) begin
      if (!nxt_found && r <= int'(rank_q) && online_w[r]) begin
        nxt_found = 1'b1;
        nxt_wrap  = 1'b1;
        nxt_rank  = 4'(r);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    rank_d       = rank_q;
    skip_d       = 1'b0;
    pass_done_d  = 1'b0;
    pass_count_d = pass_count_q;
    scrub_req    = 1'b0;
    scrub_we     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (scrub_enable && any_online) begin
          state_d = S_WAIT;
          cnt_d   = interval_load;
        end
      end
      S_WAIT: begin
        if (!scrub_enable || !any_online) begin
          state_d = S_IDLE;
        end else if (cnt_q <= 32'd1) begin
          state_d = S_REQ;
          cnt_d   = 32'd0;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      S_REQ: begin
        if (!online_w[rank_q]) begin
          skip_d  = 1'b1;
          state_d = S_ADV;
        end else begin
          scrub_req = !host_busy;
          if (scrub_req && scrub_gnt) state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rd_valid) state_d = rd_ce ? S_WB : S_ADV;
      end
      S_WB: begin
        scrub_req = !host_busy;
        scrub_we  = 1'b1;
        if (scrub_req && scrub_gnt) state_d = S_ADV;
      end
      S_ADV: begin
        if (exhausted) begin
          addr_d = '0;
          if (nxt_found) begin
            rank_d       = nxt_rank;
            pass_done_d  = nxt_wrap;
            pass_count_d = pass_count_q + {15'd0, nxt_wrap};
          end else begin
            rank_d = 4'd0;
          end
        end else begin
          addr_d = sum_w[ADDR_WIDTH-1:0];
        end
        if (scrub_enable && any_online) begin
          state_d = S_WAIT;
          cnt_d   = interval_load;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 32'd0;
      addr_q       <= '0;
      rank_q       <= 4'd0;
      skip_q       <= 1'b0;
      pass_done_q  <= 1'b0;
      pass_count_q <= 16'd0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      rank_q       <= rank_d;
      skip_q       <= skip_d;
      pass_done_q  <= pass_done_d;
      pass_count_q <= pass_count_d;
      active_q     <= (state_d != S_IDLE);
    end
  end

  assign scrub_addr     = addr_q;
  assign scrub_rank     = rank_q;
  assign scrub_active   = active_q;
  assign scrub_progress = {rank_q, 28'(addr_q)};
  assign pass_done      = pass_done_q;
  assign pass_count     = pass_count_q;

endmodule
